// File: rtl/fir_stream_ctrl_pkg.sv
// Shared definitions for the FIR stream controller and its datapath.
package fir_stream_ctrl_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  // Q8.8 filter coefficients shared with datapath_fir: 0.25, 0.5, 0.25
  localparam int unsigned COEF_FRAC_BITS = 8;
  localparam logic signed [15:0] COEF0 = 16'sd64;
  localparam logic signed [15:0] COEF1 = 16'sd128;
  localparam logic signed [15:0] COEF2 = 16'sd64;

endpackage

// File: rtl/fir_stream_ctrl.sv
// Stream-side controller for the 3-tap FIR datapath: turns a valid/ready
// sample stream into ld_reg/ld_out load sequences and presents each result
// on a valid/ready output stream with warm-up handling and a result counter.
module fir_stream_ctrl #(
  parameter int unsigned DATAWIDTH   = 16,
  parameter int unsigned TAPS        = 3,
  parameter bit          DROP_WARMUP = 1'b1,
  parameter int unsigned CNTWIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATAWIDTH-1:0]   in_data,
  input  logic                          in_last,
  output logic signed [DATAWIDTH-1:0]   dp_x,
  output logic                          dp_ld_reg,
  output logic                          dp_ld_out,
  input  logic signed [2*DATAWIDTH-1:0] dp_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [2*DATAWIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          out_warm,
  output logic [CNTWIDTH-1:0]           sample_count
);
  import fir_stream_ctrl_pkg::*;

  localparam int unsigned WARMW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [WARMW-1:0] WARM_LEN = WARMW'(TAPS - 1);

  state_t           state;
  logic             last_flag;
  logic [WARMW-1:0] warm_cnt;
  logic             is_warm;

  assign is_warm  = (warm_cnt < WARM_LEN);
  // The datapath output register is frozen while presenting, so dp_y is the result.
  assign out_data = dp_y;

  // Accept in IDLE, or in PRESENT in the same cycle the result is taken.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      PRESENT: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Control FSM with registered strobes, result flags and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dp_x         <= '0;
      dp_ld_reg    <= 1'b0;
      dp_ld_out    <= 1'b0;
      last_flag    <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_warm     <= 1'b0;
      sample_count <= '0;
      warm_cnt     <= '0;
    end else begin
      dp_ld_reg <= 1'b0;
      dp_ld_out <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dp_x      <= in_data;
            last_flag <= in_last;
            dp_ld_reg <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          dp_ld_out <= 1'b1;
          state     <= COMPUTE;
        end
        COMPUTE: begin
          if (is_warm) begin
            warm_cnt <= warm_cnt + 1'b1;
          end
          if (is_warm && DROP_WARMUP) begin
            state <= IDLE;
          end else begin
            out_valid <= 1'b1;
            out_last  <= last_flag;
            out_warm  <= is_warm;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            sample_count <= sample_count + 1'b1;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_warm     <= 1'b0;
            if (in_valid) begin
              dp_x      <= in_data;
              last_flag <= in_last;
              dp_ld_reg <= 1'b1;
              state     <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench for fir_stream_ctrl: instance 0 presents warm-up
// results, instance 1 drops them. A small datapath model supplies dp_y.
module tb_fir_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_s [2];
  logic               iv    [2];
  logic               ir    [2];
  logic signed [15:0] idat  [2];
  logic               ilast [2];
  logic signed [15:0] dx    [2];
  logic               ldr   [2];
  logic               ldo   [2];
  logic signed [31:0] dy    [2];
  logic               ov    [2];
  logic               ordy  [2];
  logic signed [31:0] odat  [2];
  logic               olast [2];
  logic               owarm [2];
  logic [15:0]        scnt  [2];

  int checks = 0;
  int failures = 0;
  int exp_count [2];

  logic signed [15:0] stim[$];
  logic signed [31:0] rx_data[$];
  bit                 rx_last[$];
  bit                 rx_warm[$];
  int                 fire_cycles[$];

  fir_stream_ctrl #(.DATAWIDTH(16), .TAPS(3), .DROP_WARMUP(1'b0), .CNTWIDTH(16)) dut0 (
    .clk(clk), .rst(rst_s[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .in_last(ilast[0]), .dp_x(dx[0]), .dp_ld_reg(ldr[0]), .dp_ld_out(ldo[0]), .dp_y(dy[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odat[0]), .out_last(olast[0]),
    .out_warm(owarm[0]), .sample_count(scnt[0]));

  fir_stream_ctrl #(.DATAWIDTH(16), .TAPS(3), .DROP_WARMUP(1'b1), .CNTWIDTH(16)) dut1 (
    .clk(clk), .rst(rst_s[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .in_last(ilast[1]), .dp_x(dx[1]), .dp_ld_reg(ldr[1]), .dp_ld_out(ldo[1]), .dp_y(dy[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odat[1]), .out_last(olast[1]),
    .out_warm(owarm[1]), .sample_count(scnt[1]));

  // Datapath stand-in: tap shift on ld_reg, registered weighted sum on ld_out.
  for (genvar g = 0; g < 2; g++) begin : g_dp
    logic signed [15:0] t0, t1, t2;
    always_ff @(posedge clk or posedge rst_s[g]) begin
      if (rst_s[g]) begin
        t0 <= '0; t1 <= '0; t2 <= '0; dy[g] <= '0;
      end else begin
        if (ldr[g]) begin
          t0 <= dx[g]; t1 <= t0; t2 <= t1;
        end
        if (ldo[g]) dy[g] <= 32'(64 * int'(t0) + 128 * int'(t1) + 64 * int'(t2));
      end
    end
  end

  function automatic logic signed [31:0] fir_ref(int x0, int x1, int x2);
    return 32'(64 * x0 + 128 * x1 + 64 * x2);
  endfunction

  task automatic apply_reset(int d);
    @(negedge clk);
    rst_s[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0; idat[d] = '0; ilast[d] = 1'b0;
    @(negedge clk);
    rst_s[d] = 1'b0;
    exp_count[d] = 0;
  endtask

  // Drive n samples from stim and check every result against the FIR equation.
  task automatic run_stream(int d, int n, int vprob, int rprob, int last_idx, bit drop);
    int hist[$];
    logic signed [31:0] eq_d[$];
    bit eq_l[$];
    bit eq_w[$];
    int idx = 0;
    int cyc = 0;
    int budget = n * 30 + 100;
    bit pending = 0;
    bit prev_ldr = 0;
    bit prev_hold = 0;
    bit in_fire, out_fire;
    logic signed [31:0] prev_dat = '0;
    logic signed [15:0] cur_x = '0;
    rx_data.delete(); rx_last.delete(); rx_warm.delete(); fire_cycles.delete();
    while (cyc < budget) begin
      @(negedge clk);
      if (!pending) begin
        iv[d] = 1'b0;
        if (idx < n && $urandom_range(99) < vprob) begin
          pending = 1; iv[d] = 1'b1; idat[d] = stim[idx]; ilast[d] = (idx == last_idx);
        end
      end
      ordy[d] = ($urandom_range(99) < rprob);
      #1;
      checks++;
      if (ldr[d] && ldo[d]) begin
        failures++; $display("FAIL strobe_excl d=%0d ld_reg=%0b ld_out=%0b required not both", d, ldr[d], ldo[d]);
      end
      checks++;
      if (ldo[d] !== prev_ldr) begin
        failures++; $display("FAIL ld_order d=%0d ld_out=%0b required=%0b", d, ldo[d], prev_ldr);
      end
      if (ldr[d]) begin
        checks++;
        if (dx[d] !== cur_x) begin
          failures++; $display("FAIL dp_x d=%0d got=%0d required=%0d", d, dx[d], cur_x);
        end
      end
      if (ldr[d] || ldo[d]) begin
        checks++;
        if (ir[d] !== 1'b0) begin
          failures++; $display("FAIL in_ready_busy d=%0d got=%0b required=0", d, ir[d]);
        end
      end
      if (prev_hold) begin
        checks++;
        if (ov[d] !== 1'b1 || odat[d] !== prev_dat) begin
          failures++; $display("FAIL hold_stable d=%0d valid=%0b data=%0d required data=%0d", d, ov[d], odat[d], prev_dat);
        end
      end
      checks++;
      if (scnt[d] !== 16'(exp_count[d])) begin
        failures++; $display("FAIL sample_count d=%0d got=%0d required=%0d", d, scnt[d], exp_count[d]);
      end
      if (idx == n && !pending && eq_d.size() == 0 && !ldr[d] && !ldo[d] && !ov[d]) break;
      in_fire  = iv[d] && ir[d];
      out_fire = ov[d] && ordy[d];
      if (out_fire) begin
        checks++;
        if (eq_d.size() == 0) begin
          failures++; $display("FAIL unexpected_out d=%0d data=%0d required no result", d, odat[d]);
        end else begin
          if (odat[d] !== eq_d[0] || olast[d] !== eq_l[0] || owarm[d] !== eq_w[0]) begin
            failures++;
            $display("FAIL result d=%0d got data=%0d last=%0b warm=%0b required data=%0d last=%0b warm=%0b",
                     d, odat[d], olast[d], owarm[d], eq_d[0], eq_l[0], eq_w[0]);
          end
          void'(eq_d.pop_front()); void'(eq_l.pop_front()); void'(eq_w.pop_front());
        end
        rx_data.push_back(odat[d]); rx_last.push_back(olast[d]); rx_warm.push_back(owarm[d]);
        exp_count[d]++;
      end
      if (in_fire) begin
        int k;
        int x1, x2;
        k = hist.size();
        hist.push_back(int'(stim[idx]));
        cur_x = stim[idx];
        x1 = (k >= 1) ? hist[k-1] : 0;
        x2 = (k >= 2) ? hist[k-2] : 0;
        if (!(drop && k < 2)) begin
          eq_d.push_back(fir_ref(hist[k], x1, x2));
          eq_l.push_back(idx == last_idx);
          eq_w.push_back(k < 2);
        end
        fire_cycles.push_back(cyc);
        idx++;
        pending = 0;
      end
      prev_ldr  = ldr[d];
      prev_hold = ov[d] && !ordy[d];
      prev_dat  = odat[d];
      cyc++;
    end
    iv[d] = 1'b0; ordy[d] = 1'b0;
    checks++;
    if (idx != n || eq_d.size() != 0) begin
      failures++; $display("FAIL timeout d=%0d sent=%0d of %0d pending_results=%0d required all done", d, idx, n, eq_d.size());
    end
  endtask

  task automatic test_reset(int d);
    #1;
    checks += 8;
    if (ir[d] !== 1'b1)    begin failures++; $display("FAIL rst_in_ready d=%0d got=%0b required=1", d, ir[d]); end
    if (ldr[d] !== 1'b0)   begin failures++; $display("FAIL rst_ld_reg d=%0d got=%0b required=0", d, ldr[d]); end
    if (ldo[d] !== 1'b0)   begin failures++; $display("FAIL rst_ld_out d=%0d got=%0b required=0", d, ldo[d]); end
    if (dx[d] !== '0)      begin failures++; $display("FAIL rst_dp_x d=%0d got=%0d required=0", d, dx[d]); end
    if (ov[d] !== 1'b0)    begin failures++; $display("FAIL rst_out_valid d=%0d got=%0b required=0", d, ov[d]); end
    if (olast[d] !== 1'b0) begin failures++; $display("FAIL rst_out_last d=%0d got=%0b required=0", d, olast[d]); end
    if (owarm[d] !== 1'b0) begin failures++; $display("FAIL rst_out_warm d=%0d got=%0b required=0", d, owarm[d]); end
    if (scnt[d] !== '0)    begin failures++; $display("FAIL rst_count d=%0d got=%0d required=0", d, scnt[d]); end
  endtask

  task automatic test_impulse();
    int exp_d [3] = '{16384, 32768, 16384};
    bit exp_w [3] = '{1'b1, 1'b1, 1'b0};
    apply_reset(0);
    stim = '{16'sd256, 16'sd0, 16'sd0};
    run_stream(0, 3, 100, 100, -1, 1'b0);
    checks++;
    if (rx_data.size() != 3) begin
      failures++; $display("FAIL impulse_count got=%0d required=3", rx_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_data[i] !== 32'(exp_d[i]) || rx_warm[i] !== exp_w[i]) begin
          failures++; $display("FAIL impulse[%0d] got data=%0d warm=%0b required data=%0d warm=%0b", i, rx_data[i], rx_warm[i], exp_d[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_warmup_drop();
    apply_reset(1);
    stim = '{16'sd256, 16'sd256, 16'sd256, 16'sd256};
    run_stream(1, 4, 100, 100, -1, 1'b1);
    checks++;
    if (rx_data.size() != 2) begin
      failures++; $display("FAIL drop_count got=%0d required=2", rx_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rx_data[i] !== 32'sd65536) begin
          failures++; $display("FAIL drop_data[%0d] got=%0d required=65536", i, rx_data[i]);
        end
      end
    end
    checks++;
    if (scnt[1] !== 16'd2) begin
      failures++; $display("FAIL drop_sample_count got=%0d required=2", scnt[1]);
    end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] expv;
    apply_reset(1);
    stim = '{16'sd100, -16'sd200, 16'sd300};
    run_stream(1, 3, 100, 100, -1, 1'b1);
    expv = fir_ref(50, 300, -200);
    @(negedge clk);
    iv[1] = 1'b1; idat[1] = 16'sd50; ilast[1] = 1'b0; ordy[1] = 1'b0;
    #1;
    checks++;
    if (ir[1] !== 1'b1) begin failures++; $display("FAIL bp_idle_ready got=%0b required=1", ir[1]); end
    @(negedge clk);
    iv[1] = 1'b0;
    for (int i = 0; i < 10 && ov[1] !== 1'b1; i++) @(negedge clk);
    checks++;
    if (ov[1] !== 1'b1) begin failures++; $display("FAIL bp_wait_valid got=%0b required=1", ov[1]); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (odat[1] !== expv || ov[1] !== 1'b1 || ir[1] !== 1'b0 || ldo[1] !== 1'b0 || scnt[1] !== 16'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got data=%0d valid=%0b in_ready=%0b ld_out=%0b count=%0d required %0d/1/0/0/1",
                 i, odat[1], ov[1], ir[1], ldo[1], scnt[1], expv);
      end
      @(negedge clk);
    end
    ordy[1] = 1'b1;
    #1;
    checks++;
    if (ir[1] !== 1'b1) begin failures++; $display("FAIL bp_ready_follow got=%0b required=1", ir[1]); end
    @(negedge clk);
    ordy[1] = 1'b0;
    #1;
    checks++;
    if (scnt[1] !== 16'd2 || ov[1] !== 1'b0) begin
      failures++; $display("FAIL bp_release got count=%0d valid=%0b required count=2 valid=0", scnt[1], ov[1]);
    end
    exp_count[1] = 2;
  endtask

  task automatic test_back_to_back(int d);
    apply_reset(d);
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(16'($urandom));
    run_stream(d, 12, 100, 100, -1, d == 1);
    for (int i = 1; i < fire_cycles.size(); i++) begin
      checks++;
      if (fire_cycles[i] - fire_cycles[i-1] != 3) begin
        failures++; $display("FAIL b2b_spacing d=%0d idx=%0d got=%0d required=3", d, i, fire_cycles[i] - fire_cycles[i-1]);
      end
    end
  endtask

  task automatic test_random(int d);
    apply_reset(d);
    stim.delete();
    for (int i = 0; i < 30; i++) stim.push_back(16'($urandom));
    run_stream(d, 30, 60, 50, -1, d == 1);
  endtask

  task automatic test_last();
    int ones = 0;
    apply_reset(1);
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(16'($urandom_range(1000)));
    run_stream(1, 8, 100, 100, 4, 1'b1);
    foreach (rx_last[i]) if (rx_last[i]) ones++;
    checks++;
    if (ones != 1 || rx_last.size() < 3 || rx_last[2] !== 1'b1) begin
      failures++; $display("FAIL last_tag got ones=%0d results=%0d required one tag on 3rd result", ones, rx_last.size());
    end
  endtask

  task automatic test_async_reset();
    apply_reset(1);
    stim = '{16'sd7, 16'sd9};
    run_stream(1, 2, 100, 100, -1, 1'b1);
    @(negedge clk);
    iv[1] = 1'b1; idat[1] = 16'sd256;
    @(negedge clk);
    iv[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (ldo[1] !== 1'b1) begin failures++; $display("FAIL ar_in_compute ld_out=%0b required=1", ldo[1]); end
    #2 rst_s[1] = 1'b1;
    #1;
    checks++;
    if (ir[1] !== 1'b1 || ldo[1] !== 1'b0 || ldr[1] !== 1'b0 || ov[1] !== 1'b0 || dx[1] !== '0 || scnt[1] !== '0) begin
      failures++;
      $display("FAIL ar_values got in_ready=%0b ld_out=%0b ld_reg=%0b valid=%0b dp_x=%0d count=%0d required 1/0/0/0/0/0",
               ir[1], ldo[1], ldr[1], ov[1], dx[1], scnt[1]);
    end
    @(negedge clk);
    rst_s[1] = 1'b0;
    exp_count[1] = 0;
    stim = '{16'sd256, 16'sd256, 16'sd256};
    run_stream(1, 3, 100, 100, -1, 1'b1);
    checks++;
    if (rx_data.size() != 1 || rx_data[0] !== 32'sd65536) begin
      failures++; $display("FAIL ar_warmup got results=%0d required one result of 65536", rx_data.size());
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0; idat[d] = '0; ilast[d] = 1'b0; exp_count[d] = 0;
    end
    repeat (2) @(negedge clk);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    test_reset(0);
    test_reset(1);
    test_impulse();
    test_warmup_drop();
    test_backpressure();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random(0);
    test_random(1);
    test_last();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
